// File: rtl/inst_queue_param.sv
// Parametrised instruction queue between IFetch and issue: circular buffer of
// (pc, inst) pairs with combinational head view and a registered issue pulse.
module inst_queue_param #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  parameter int SLACK = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            almost_full,
  output logic            full,
  output logic            empty,
  output logic [CW-1:0]   count,
  output logic            overflow,
  output logic [XLEN-1:0] head_inst,
  output logic [XLEN-1:0] head_pc,
  input  logic            issue_en,
  input  logic            ops_ok,
  output logic            out_valid,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(DEPTH - SLACK);

  logic [XLEN-1:0] ins_que [DEPTH];
  logic [XLEN-1:0] pc_que  [DEPTH];
  logic [PW-1:0]   head, tail;
  logic            do_deq, do_enq, drop;

  assign full        = (count == CNT_FULL);
  assign empty       = (count == '0);
  assign almost_full = (count >= CNT_AF);

  assign head_inst = ins_que[head];
  assign head_pc   = pc_que[head];

  // A full queue may still accept when the head leaves in the same cycle.
  assign do_deq = issue_en && ops_ok && !empty;
  assign do_enq = in_valid && (!full || do_deq);
  assign drop   = in_valid && full && !do_deq;

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= '0;
    end else if (rdy) begin
      if (flush) begin
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= do_deq;
        if (do_deq) begin
          out_inst <= head_inst;
          out_pc   <= head_pc;
          head     <= head + 1'b1;
        end
        if (do_enq)
          tail <= tail + 1'b1;
        if (do_enq && !do_deq)
          count <= count + 1'b1;
        else if (!do_enq && do_deq)
          count <= count - 1'b1;
        if (drop)
          overflow <= 1'b1;
      end
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !flush && do_enq) begin
      ins_que[tail] <= in_inst;
      pc_que[tail]  <= in_pc;
    end
  end

endmodule

// File: doc/inst_queue_param.md
Name: inst_queue_param

Overview:
- Parametrised successor to the single-issue instruction queue; sits between IFetch and the issue/decode stage.
- Buffers fetched (pc, inst) pairs in a circular buffer of DEPTH entries and exposes the head entry combinationally so external decode can compute source registers.
- Issues the head as a registered one-cycle pulse when downstream and operand readiness allow.
- Adds what the previous queue lacked:
  - count-based full/empty with no wasted slots
  - programmable fetch slack (almost_full)
  - flush for branch mispredict
  - sticky overflow flag
  - occupancy output

Parameters:
- DEPTH, 16, number of entries; power of two, at least 4.
- XLEN, 32, width of inst and pc.
- SLACK, 2, in-flight fetches IFetch may still deliver after seeing almost_full; 1 ≤ SLACK < DEPTH.
- CW, $clog2(DEPTH)+1, count width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  global enable; when low all state holds.
- flush  in  1  discard all entries (mispredict).
- in_valid  in  1  IFetch delivers an instruction this cycle.
- in_inst  in  XLEN  instruction word.
- in_pc  in  XLEN  its pc.
- almost_full  out  1  count ≥ DEPTH−SLACK; combinational from count.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  CW  current occupancy.
- overflow  out  1  sticky: a write was dropped.
- head_inst  out  XLEN  combinational ins_que[head]; undefined-but-stable when empty.
- head_pc  out  XLEN  combinational pc_que[head].
- issue_en  in  1  downstream can accept (reservation/forward ready).
- ops_ok  in  1  operands of the head entry are ready.
- out_valid  out  1  registered one-cycle issue pulse.
- out_inst  out  XLEN  registered issued instruction.
- out_pc  out  XLEN  registered issued pc.

Behaviour:

Reset:
- rst high at posedge: head = tail = 0, count = 0, overflow = 0, out_valid = 0, out_inst = 0, out_pc = 0.
- Storage array is not cleared.

Enable:
- rdy low: no pointer, count, storage, flag or output change.
- out_valid holds its previous value.

Flush (rdy high):
- Highest priority.
- head = tail = 0, count = 0, out_valid = 0.
- Any same-cycle in_valid is discarded without setting overflow.
- overflow is not cleared; only rst clears it.

Dequeue (do_deq):
- do_deq = issue_en && ops_ok && !empty.
- On do_deq: out_inst/out_pc take head_inst/head_pc, out_valid = 1, head = head+1 mod DEPTH.
- Otherwise out_valid = 0 the next cycle.
- out_inst/out_pc hold their last value when not issuing.

Enqueue (do_enq):
- do_enq = in_valid && (!full || do_deq).
- Write is allowed when full if the same cycle dequeues.
- On do_enq: write slot tail, tail = tail+1 mod DEPTH.
- in_valid && full && !do_deq: write dropped, overflow = 1, no state corruption.

Count and pointers:
- count_next = count + do_enq − do_deq.
- Simultaneous enq/deq leaves count unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally.

Latency:
- Entry enqueued at edge N appears on head_* after edge N.
- Earliest out_valid for it is the cycle after edge N+1.
- Empty → enqueue → issue takes two edges.
- Sustained throughput is one issue per cycle.

Invariants:
- Entries issue in write order.
- No entry issues twice.
- count never exceeds DEPTH.
- full and empty are never both high.

Test Plan:
- Reset then 3 writes (pc 0x00/0x04/0x08), issue_en=ops_ok=1 → out_valid pulses on 3 consecutive cycles with out_pc 0x00, 0x04, 0x08; count returns to 0, empty=1.
- Fill with issue_en=0, DEPTH=16, SLACK=2 → almost_full rises when count reaches 14; full at 16; 17th in_valid → dropped, overflow=1 sticky, count stays 16.
- Full queue, in_valid and do_deq in same cycle → count stays 16, new entry written at wrapped tail, later issued last in order.
- ops_ok=0 while issue_en=1 and queue non-empty → out_valid=0, head and count unchanged; ops_ok=1 next cycle → head issues.
- 5 entries queued, flush together with in_valid → count=0, empty=1, out_valid=0 next cycle; the flushed-cycle write never issues; subsequent write at pc 0x100 issues first.
- rdy=0 for 3 cycles with in_valid and issue_en asserted → no count, pointer or output change; operation resumes identically when rdy returns high.
